// File: rtl/half_subtractor.sv
// half_subtractor: WIDTH independent 1-bit half subtractors with registered outputs and one cycle of latency.
// Optional feature macro HALF_SUB_BORROW_CNT_EN adds a saturating lane-borrow event counter on borrow_cnt.
module half_subtractor #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] barrow,
  output logic             out_valid
`ifdef HALF_SUB_BORROW_CNT_EN
  ,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("half_subtractor: WIDTH and CNT_W must both be at least 1");
  end

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_borrow;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_barrow;
  logic             r_valid;

  assign w_diff   = a ^ b;
  assign w_borrow = ~a & b;

  // Data registers hold their value while in_valid is low, so X on idle inputs never reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff   <= '0;
      r_barrow <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_diff   <= w_diff;
        r_barrow <= w_borrow;
      end
    end
  end

  assign diff      = r_diff;
  assign barrow    = r_barrow;
  assign out_valid = r_valid;

`ifdef HALF_SUB_BORROW_CNT_EN
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PC_W'(w_borrow[i]);
    end
  end

  // Sum is one bit wider than either operand so overflow is visible before clamping to all-ones.
  assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
  assign w_cnt_nxt = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign borrow_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// tb_half_subtractor: directed and random stimulus on a 1-lane (CNT_W=2) and a 4-lane instance,
// checked against an arithmetic reference model (per-lane a-b as integers).
module tb_half_subtractor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v1, v4;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [0:0] o1_diff, o1_bor;
  logic [3:0] o4_diff, o4_bor;
  logic       o1_v, o4_v;
`ifdef HALF_SUB_BORROW_CNT_EN
  logic [1:0]  o1_cnt;
  logic [15:0] o4_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [3:0] e1_d, e1_b, e4_d, e4_b;
  logic       e1_v, e4_v;
  int         e1_c, e4_c;
  localparam int C1_MAX = 3;
  localparam int C4_MAX = 65535;

  half_subtractor #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .diff(o1_diff), .barrow(o1_bor), .out_valid(o1_v)
`ifdef HALF_SUB_BORROW_CNT_EN
    , .borrow_cnt(o1_cnt)
`endif
  );

  half_subtractor #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .diff(o4_diff), .barrow(o4_bor), .out_valid(o4_v)
`ifdef HALF_SUB_BORROW_CNT_EN
    , .borrow_cnt(o4_cnt)
`endif
  );

  // Reference: lane difference as a signed integer; nonzero means diff, negative means borrow.
  task automatic model(input logic r, input logic v, input int w, input logic [3:0] a, input logic [3:0] b,
                       input int cmax, inout logic [3:0] ed, inout logic [3:0] eb, inout logic ev, inout int ec);
    int d, n;
    if (r) begin
      ed = '0; eb = '0; ev = 1'b0; ec = 0;
    end else begin
      ev = v;
      if (v) begin
        n = 0;
        ed = '0; eb = '0;
        for (int i = 0; i < w; i++) begin
          d = int'(a[i]) - int'(b[i]);
          ed[i] = (d != 0);
          eb[i] = (d < 0);
          if (d < 0) n++;
        end
        ec = (ec + n > cmax) ? cmax : ec + n;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w1_diff",  {15'b0, o1_diff}, {15'b0, e1_d[0]});
    chk("w1_bor",   {15'b0, o1_bor},  {15'b0, e1_b[0]});
    chk("w1_valid", {15'b0, o1_v},    {15'b0, e1_v});
    chk("w4_diff",  {12'b0, o4_diff}, {12'b0, e4_d});
    chk("w4_bor",   {12'b0, o4_bor},  {12'b0, e4_b});
    chk("w4_valid", {15'b0, o4_v},    {15'b0, e4_v});
`ifdef HALF_SUB_BORROW_CNT_EN
    chk("w1_cnt", {14'b0, o1_cnt}, 16'(e1_c));
    chk("w4_cnt", o4_cnt,          16'(e4_c));
`endif
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the next edge.
  task automatic step(input logic r, input logic v1_i, input logic a1_i, input logic b1_i,
                      input logic v4_i, input logic [3:0] a4_i, input logic [3:0] b4_i);
    rst = r; v1 = v1_i; a1 = a1_i; b1 = b1_i; v4 = v4_i; a4 = a4_i; b4 = b4_i;
    model(r, v1_i, 1, {3'b0, a1_i}, {3'b0, b1_i}, C1_MAX, e1_d, e1_b, e1_v, e1_c);
    model(r, v4_i, 4, a4_i, b4_i, C4_MAX, e4_d, e4_b, e4_v, e4_c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic       r, va, vb, xa, xb;
    logic [3:0] ra, rb;
    e1_d = '0; e1_b = '0; e1_v = 1'b0; e1_c = 0;
    e4_d = '0; e4_b = '0; e4_v = 1'b0; e4_c = 0;
    rst = 1'b1; v1 = 1'b0; v4 = 1'b0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    @(posedge clk);
    #1;

    // Reset held two cycles with valid high and a=b=1 on every lane.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);

    // Truth table back-to-back on one lane, lane independence on four lanes.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100, 4'b1010);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 4'b0110);

    // Hold: last valid result retained while idle, idle inputs may even be X.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 4'b0101);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF,    4'hF);
    step(1'b0, 1'b0, 1'bx, 1'bx, 1'b0, 4'bxxxx, 4'bxxxx);

    // Mid-stream reset and clean resume.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1001, 4'b0110);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b0111);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 4'b0011);

    // Borrow counter: five borrowing inputs after reset, 2-bit counter clamps at 3.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111);

    // Random traffic with occasional reset and X on idle inputs.
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 24) == 0);
      va = $urandom_range(0, 3) != 0;
      vb = $urandom_range(0, 3) != 0;
      ra = 4'($urandom);
      rb = 4'($urandom);
      xa = ra[0];
      xb = rb[1];
      if (!va && !r) begin xa = 1'bx; xb = 1'bx; end
      if (!vb && !r) begin ra = 4'bxxxx; rb = 4'bxxxx; end
      step(r, va, xa, xb, vb, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
